// File: rtl/gc.sv
// Shared IO direction encoding used by the arbiter and its slot clients.
package gc;
  localparam logic IO_IN  = 1'b1;
  localparam logic IO_OUT = 1'b0;
endpackage

// File: rtl/io_slot_client.sv
// Per-device request queue feeding one IO arbiter slot; presents the head
// request to the arbiter and retires it on the slot's grant.
module io_slot_client #(
  parameter int WORD_SIZE = 8,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_write,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  input  logic                 slot_valid,
  input  logic [WORD_SIZE-1:0] slot_rdata,
  output logic [WORD_SIZE-1:0] arb_addr,
  output logic [WORD_SIZE-1:0] arb_wdata,
  output logic                 arb_dir,
  output logic                 busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic                 r_mem_write [DEPTH];
  logic [WORD_SIZE-1:0] r_mem_addr  [DEPTH];
  logic [WORD_SIZE-1:0] r_mem_wdata [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_rsp_valid;
  logic                 r_rsp_write;
  logic [WORD_SIZE-1:0] r_rsp_rdata;

  logic w_push;
  logic w_pop;
  logic w_busy;

  // Ready and busy depend on occupancy only, so no loop through device or arbiter.
  assign w_busy    = (r_count != '0);
  assign req_ready = (r_count != FULL_CNT);
  assign busy      = w_busy;
  assign w_push    = req_valid & req_ready;
  assign w_pop     = slot_valid & w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_write[i] <= 1'b0;
        r_mem_addr[i]  <= '0;
        r_mem_wdata[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_write[r_wr_ptr] <= req_write;
      r_mem_addr[r_wr_ptr]  <= req_addr;
      r_mem_wdata[r_wr_ptr] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_pop;
      if (w_pop) begin
        r_rsp_write <= r_mem_write[r_rd_ptr];
        r_rsp_rdata <= r_mem_write[r_rd_ptr] ? '0 : slot_rdata;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;

  // Stale storage behind rd_ptr must not leak out while empty.
  assign arb_addr  = w_busy ? r_mem_addr[r_rd_ptr]  : '0;
  assign arb_wdata = w_busy ? r_mem_wdata[r_rd_ptr] : '0;
  assign arb_dir   = (w_busy && r_mem_write[r_rd_ptr]) ? gc::IO_IN : gc::IO_OUT;

endmodule

// File: tb/tb_io_slot_client.sv
// Directed bench for io_slot_client with a queue model of pending requests
// and a response monitor that checks every cycle.
module tb_io_slot_client;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_write;
  logic [7:0] rsp_rdata;
  logic       slot_valid;
  logic [7:0] slot_rdata;
  logic [7:0] arb_addr, arb_wdata;
  logic       arb_dir, busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {logic w; logic [7:0] a; logic [7:0] d;} req_t;
  typedef struct {logic w; logic [7:0] r;} rsp_t;
  req_t mq[$];
  rsp_t eq[$];

  always #5 clk = ~clk;

  io_slot_client #(.WORD_SIZE(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .slot_valid(slot_valid), .slot_rdata(slot_rdata),
    .arb_addr(arb_addr), .arb_wdata(arb_wdata), .arb_dir(arb_dir), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check presented head against the model, drive, clock, update model.
  task automatic cyc(input logic v, input logic w, input logic [7:0] a, input logic [7:0] d,
                     input logic g, input logic [7:0] rd, output logic acc);
    check_val("req_ready", 32'(req_ready), 32'(mq.size() < 4));
    check_val("busy", 32'(busy), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check_val("arb_addr", 32'(arb_addr), 32'(mq[0].a));
      check_val("arb_wdata", 32'(arb_wdata), 32'(mq[0].d));
      check_val("arb_dir", 32'(arb_dir), 32'(mq[0].w ? gc::IO_IN : gc::IO_OUT));
    end else begin
      check_val("arb_addr_empty", 32'(arb_addr), 32'h0);
      check_val("arb_dir_empty", 32'(arb_dir), 32'(gc::IO_OUT));
    end
    acc = v && (mq.size() < 4);
    req_valid  = v;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    slot_valid = g;
    slot_rdata = rd;
    @(posedge clk); #1;
    if (g && mq.size() > 0) begin
      eq.push_back('{mq[0].w, mq[0].w ? 8'h00 : rd});
      void'(mq.pop_front());
    end
    if (acc) mq.push_back('{w, a, d});
    req_valid  = 1'b0;
    slot_valid = 1'b0;
  endtask

  // Every cycle: a response is expected exactly when the model retired an entry.
  always @(posedge clk) begin
    #2;
    if (eq.size() > 0) begin
      check_val("rsp_valid", 32'(rsp_valid), 32'h1);
      check_val("rsp_write", 32'(rsp_write), 32'(eq[0].w));
      check_val("rsp_rdata", 32'(rsp_rdata), 32'(eq[0].r));
      void'(eq.pop_front());
    end else begin
      check_val("rsp_valid_idle", 32'(rsp_valid), 32'h0);
    end
  end

  logic acc;
  int   sent;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    slot_valid = 1'b0; slot_rdata = '0;
    #12;
    check_val("rst_req_ready", 32'(req_ready), 32'h1);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_val("rst_rsp_write", 32'(rsp_write), 32'h0);
    check_val("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    check_val("rst_arb_addr", 32'(arb_addr), 32'h0);
    check_val("rst_arb_wdata", 32'(arb_wdata), 32'h0);
    check_val("rst_arb_dir", 32'(arb_dir), 32'(gc::IO_OUT));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset mid-queue: three pending requests dropped without responses.
    cyc(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, acc);
    cyc(1'b1, 1'b1, 8'h02, 8'h11, 1'b0, 8'h00, acc);
    cyc(1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 8'h00, acc);
    check_val("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(busy), 32'h0);
    check_val("mid_rst_ready", 32'(req_ready), 32'h1);
    check_val("mid_rst_dir", 32'(arb_dir), 32'(gc::IO_OUT));
    check_val("mid_rst_addr", 32'(arb_addr), 32'h0);
    mq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h55, acc);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h55, acc);

    // Single read: head held until the grant, then data A5 returned.
    cyc(1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 8'h00, acc);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, acc);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hA5, acc);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, acc);

    // Single write: IO_IN head; slot data ignored, response data zero.
    cyc(1'b1, 1'b1, 8'h30, 8'h5C, 1'b0, 8'h00, acc);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, acc);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h77, acc);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, acc);
    check_val("wr_wdata_cleared", 32'(arb_wdata), 32'h0);

    // Fill and back-pressure: six reads held until accepted, grants every third cycle from cycle 4.
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      if (sent == 6 && mq.size() == 0) break;
      cyc(sent < 6, 1'b0, 8'(sent + 1), 8'h00, (c >= 4) && ((c - 4) % 3 == 0),
          8'(8'hC0 + c), acc);
      if (acc) sent++;
    end
    check_val("fill_sent", 32'(sent), 32'd6);
    check_val("fill_drained", 32'(mq.size()), 32'd0);

    // Simultaneous push and pop at occupancy two.
    cyc(1'b1, 1'b0, 8'h21, 8'h00, 1'b0, 8'h00, acc);
    cyc(1'b1, 1'b1, 8'h22, 8'hB2, 1'b0, 8'h00, acc);
    cyc(1'b1, 1'b0, 8'h23, 8'h00, 1'b1, 8'hD1, acc);
    check_val("simul_occupancy", 32'(mq.size()), 32'd2);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hD2, acc);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hD3, acc);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, acc);

    // Empty grants, then nine requests to wrap the pointers.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h99, acc);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, i[0], 8'(8'h40 + i), 8'(8'h90 + i), 1'b0, 8'h00, acc);
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(8'hB0 + i), acc);
    end

    // Grant held every cycle while pushing every cycle, including empty-queue push plus grant.
    for (int i = 0; i < 6; i++)
      cyc(1'b1, ~i[0], 8'(8'h60 + i), 8'(8'h70 + i), 1'b1, 8'(8'hE0 + i), acc);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(8'hF0 + i), acc);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, acc);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, acc);
    check_val("rsp_leftover", 32'(eq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_slot_client.md
# io_slot_client

Per-device request queue sitting directly upstream of the IO arbiter: one instance per IO device (VGA, keyboard, ...), bound to one arbiter slot index. It buffers the device's memory read/write requests. It presents the head request on its slot's address/data/direction lines and retires that request on the cycle its slot is granted. For reads, it returns the captured data to the device.

## Interface
Parameters:
- WORD_SIZE, 8, width of address and data words (same value as the arbiter instance)
- DEPTH, 4, request queue entries; power of two, ≥ 2

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  device offers a request
- req_ready  output  1  queue can accept; high whenever occupancy < DEPTH
- req_write  input  1  1 = write memory, 0 = read memory
- req_addr  input  WORD_SIZE  target address
- req_wdata  input  WORD_SIZE  write data (ignored for reads)
- rsp_valid  output  1  one-cycle pulse: head request retired
- rsp_write  output  1  type of the retired request
- rsp_rdata  output  WORD_SIZE  read data of retired read; 0 after a write
- slot_valid  input  1  this device's grant from the arbiter (its dataValid bit)
- slot_rdata  input  WORD_SIZE  memory data returned by the arbiter for this slot
- arb_addr  output  WORD_SIZE  address presented to the arbiter
- arb_wdata  output  WORD_SIZE  write data presented to the arbiter
- arb_dir  output  1  gc::IO_IN for a write head, gc::IO_OUT for a read head or empty queue
- busy  output  1  queue non-empty

## Operation
- Circular FIFO: storage of {write, addr, wdata} × DEPTH.
  - wr_ptr, rd_ptr: log2(DEPTH) bits each, wrap modulo DEPTH.
  - count: log2(DEPTH)+1 bits, range 0..DEPTH.
- Push: at a rising edge with req_valid & req_ready, the request is stored at wr_ptr and wr_ptr increments.
- Pop: at a rising edge with slot_valid & busy:
  - the head retires and rd_ptr increments;
  - rsp_valid is set high for the following cycle, with rsp_write = head.write;
  - for a read, rsp_rdata = slot_rdata sampled at that edge; for a write, rsp_rdata = 0.
- Head presentation: arb_addr, arb_wdata and arb_dir are driven from the FIFO entry at rd_ptr, so they change only after a clock edge.
- Empty queue: arb_dir = gc::IO_OUT, arb_addr = 0, arb_wdata = 0; slot grants are ignored (no pop, no rsp_valid).
- Simultaneous push and pop: both happen and count is unchanged. This is allowed at any occupancy below DEPTH.
- Full queue: req_ready = 0, even if a pop occurs in the same cycle. There is no bypass of a full queue.
- Empty-queue push: no same-edge bypass. A request pushed at edge E is first eligible to retire at edge E+1.
- Responses are returned strictly in request order, one per slot grant at most.
- Reset (rst_n low, at any time):
  - pointers, count and storage are cleared immediately;
  - pending requests are discarded without a response;
  - outputs: req_ready = 1, rsp_valid = 0, rsp_write = 0, rsp_rdata = 0, arb_addr = 0, arb_wdata = 0, arb_dir = gc::IO_OUT, busy = 0.

## Timing
- req_ready and busy are combinational from count only. They do not depend on req_valid or slot_valid, so there are no combinational loops with the device or the arbiter.
- rsp_* outputs are registered. rsp_valid stays high for exactly one cycle per retired request.
- Minimum latency: push at edge E, grant at edge E+1, rsp_valid high in the cycle after E+1.
- With IO_COUNT slots, worst-case wait for the head is IO_COUNT edges after it becomes head.
- Sustained throughput is one request per IO_COUNT cycles.
- slot_valid is assumed to be high for single cycles (round-robin). A grant held for consecutive cycles retires one entry per cycle.

## Test plan
- Reset mid-queue:
  - Stimulus: push 3 requests, assert rst_n = 0 for 1 cycle before any grant.
  - Required: busy = 0, req_ready = 1, arb_dir = gc::IO_OUT, no rsp_valid ever for the dropped requests.
- Single read:
  - Stimulus: push read to addr 0x12; slot_rdata = 0xA5 at the next grant edge.
  - Required: arb_addr = 0x12 with arb_dir = IO_OUT until the grant; rsp_valid pulse with rsp_write = 0, rsp_rdata = 0xA5; busy = 0 afterwards.
- Single write:
  - Stimulus: push write addr 0x30, data 0x5C.
  - Required: arb_dir = IO_IN, arb_addr = 0x30, arb_wdata = 0x5C until the grant; then rsp_valid with rsp_write = 1, rsp_rdata = 0.
- Fill and back-pressure (DEPTH = 4, grants every 3 cycles):
  - Stimulus: push 6 back-to-back requests (addresses 1..6).
  - Required: req_ready drops after the 4th accept while no grant has occurred; responses arrive in order 1..6; count never exceeds 4.
- Simultaneous push and pop at count = 2:
  - Required: count stays 2; the new entry is retired 2 grants later.
- Empty-queue grant and wrap:
  - Stimulus: grants with the queue empty, then 9 sequential requests.
  - Required: no rsp_valid while empty; pointer wrap preserves order and data for all 9 requests.
